// File: rtl/uart_core_if.sv
// uart_core_if: bus-side TX/RX valid/ready bundle for uart_core
interface uart_core_if #(parameter int DATA_BITS = 8);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 rx_parity_err;
  logic                 rx_frame_err;
  logic                 rx_overrun;
  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun
  );
  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun
  );
endinterface

// File: rtl/uart_core.sv
// uart_core: 16x-oversampled full-duplex UART with valid/ready TX and RX sides
module uart_core #(
  parameter int BAUD_DIV  = 27,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  uart_core_if.slave bus,
  output logic       tx_o,
  input  logic       rx_i
);
  localparam int         CW     = $clog2(BAUD_DIV);
  localparam logic [2:0] LAST_D = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_S = 3'(STOP_BITS - 1);
  localparam logic       ODD    = (PARITY == 2);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  logic [CW-1:0] div_q;
  logic          tick;
  assign tick = div_q == CW'(BAUD_DIV - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) div_q <= '0;
    else div_q <= tick ? '0 : div_q + 1'b1;
  state_t               tx_st_q, tx_st_d;
  logic [3:0]           tx_cnt_q, tx_cnt_d;
  logic [2:0]           tx_idx_q, tx_idx_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic                 tx_par_q, tx_par_d, tx_end, tx_done, tx_rdy;
  assign tx_end = tick && tx_cnt_q == 4'hf;
  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tick ? tx_cnt_q + 4'd1 : tx_cnt_q;
    tx_idx_d = tx_idx_q;
    tx_sh_d  = tx_sh_q;
    tx_par_d = tx_par_q;
    tx_done  = 1'b0;
    case (tx_st_q)
      START: if (tx_end) tx_st_d = DATA;
      DATA: if (tx_end) begin
        tx_sh_d  = tx_sh_q >> 1;
        tx_idx_d = tx_idx_q == LAST_D ? '0 : tx_idx_q + 3'd1;
        if (tx_idx_q == LAST_D) tx_st_d = PARITY != 0 ? PAR : STOP;
      end
      PAR: if (tx_end) tx_st_d = STOP;
      STOP: if (tx_end) begin
        tx_done  = tx_idx_q == LAST_S;
        tx_idx_d = tx_done ? '0 : tx_idx_q + 3'd1;
        if (tx_done) tx_st_d = IDLE;
      end
      default: ;
    endcase
    // ready on the final stop cycle lets a new frame start with no idle gap
    tx_rdy = tx_st_q == IDLE || tx_done;
    if (bus.tx_valid && tx_rdy) begin
      tx_st_d  = START;
      tx_cnt_d = '0;
      tx_idx_d = '0;
      tx_sh_d  = bus.tx_data;
      tx_par_d = ^bus.tx_data ^ ODD;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tx_st_q  <= IDLE;
      tx_cnt_q <= '0;
      tx_idx_q <= '0;
      tx_sh_q  <= '0;
      tx_par_q <= 1'b0;
    end else begin
      tx_st_q  <= tx_st_d;
      tx_cnt_q <= tx_cnt_d;
      tx_idx_q <= tx_idx_d;
      tx_sh_q  <= tx_sh_d;
      tx_par_q <= tx_par_d;
    end
  assign bus.tx_ready = tx_rdy;
  assign tx_o = tx_st_q == START ? 1'b0 : tx_st_q == DATA ? tx_sh_q[0] : tx_st_q == PAR ? tx_par_q : 1'b1;
  logic                 rx_s1_q, rx_s2_q, rx_prev_q;
  state_t               rx_st_q, rx_st_d;
  logic [3:0]           rx_cnt_q, rx_cnt_d;
  logic [2:0]           rx_idx_q, rx_idx_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic                 rx_par_q, rx_par_d, rx_samp, rx_done;
  logic                 rx_valid_q, rx_valid_d, rx_perr_q, rx_perr_d;
  logic                 rx_ferr_q, rx_ferr_d, rx_ovr_q, rx_ovr_d;
  // start bit is sampled after 8 ticks, every later bit 16 ticks on: mid-bit
  assign rx_samp = tick && rx_cnt_q == (rx_st_q == START ? 4'd7 : 4'd15);
  always_comb begin
    rx_st_d    = rx_st_q;
    rx_cnt_d   = rx_samp ? '0 : tick ? rx_cnt_q + 4'd1 : rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_sh_d    = rx_sh_q;
    rx_par_d   = rx_par_q;
    rx_done    = 1'b0;
    case (rx_st_q)
      IDLE: if (rx_prev_q && !rx_s2_q) begin
        rx_st_d  = START;
        rx_cnt_d = '0;
        rx_idx_d = '0;
      end
      START: if (rx_samp) rx_st_d = rx_s2_q ? IDLE : DATA;
      DATA: if (rx_samp) begin
        rx_sh_d  = {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
        rx_idx_d = rx_idx_q + 3'd1;
        if (rx_idx_q == LAST_D) rx_st_d = PARITY != 0 ? PAR : STOP;
      end
      PAR: if (rx_samp) begin
        rx_par_d = rx_s2_q;
        rx_st_d  = STOP;
      end
      STOP: if (rx_samp) begin
        rx_st_d = IDLE;
        rx_done = 1'b1;
      end
      default: ;
    endcase
    // draining first means a same-cycle completion refills instead of overrunning
    rx_valid_d = rx_valid_q && !bus.rx_ready;
    rx_data_d  = rx_data_q;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = rx_ferr_q;
    rx_ovr_d   = rx_done && rx_valid_d;
    if (rx_done && !rx_valid_d) begin
      rx_valid_d = 1'b1;
      rx_data_d  = rx_sh_q;
      rx_perr_d  = (PARITY != 0) && (rx_par_q != (^rx_sh_q ^ ODD));
      rx_ferr_d  = !rx_s2_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_st_q    <= IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_sh_q    <= '0;
      rx_par_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      rx_s1_q    <= rx_i;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_st_q    <= rx_st_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_sh_q    <= rx_sh_d;
      rx_par_q   <= rx_par_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  assign bus.rx_data       = rx_data_q;
  assign bus.rx_valid      = rx_valid_q;
  assign bus.rx_parity_err = rx_perr_q;
  assign bus.rx_frame_err  = rx_ferr_q;
  assign bus.rx_overrun    = rx_ovr_q;
endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: random loopback and hand-built RX frames checked by a scoreboard
module tb_uart_core;
  localparam int BIT = 64;
  logic clk = 1'b0, rst_n = 1'b0, loop = 1'b1, drv_rx = 1'b1, tx, rx;
  always #5 clk = ~clk;
  uart_core_if #(.DATA_BITS(8)) bus ();
  assign rx = loop ? tx : drv_rx;
  uart_core #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .tx_o(tx), .rx_i(rx)
  );
  typedef struct { logic [7:0] d; logic pe; logic fe; } exp_t;
  exp_t exp_q[$];
  int errs = 0, checks = 0, ovr_cnt = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.rx_overrun) ovr_cnt++;
    if (rst_n && bus.rx_valid && bus.rx_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL rx_unexpected: got data 0x%0h with nothing expected", bus.rx_data);
      end else begin
        e = exp_q.pop_front();
        chk("rx_frame{data,pe,fe}", 32'({bus.rx_data, bus.rx_parity_err, bus.rx_frame_err}),
            32'({e.d, e.pe, e.fe}));
      end
    end
  end
  task automatic send_tx(input logic [7:0] b, input bit push);
    int n = 0;
    @(negedge clk);
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    while (!bus.tx_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errs++;
      $display("FAIL tx_accept_timeout: tx_ready=0 after %0d cycles, required 1", n);
    end else if (push) exp_q.push_back('{b, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'($urandom);
  endtask
  task automatic drive_rx(input logic [7:0] b, input bit bad_par, input bit stop);
    logic [10:0] f;
    f = {stop, (^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drv_rx = f[i];
      repeat (BIT - 1) @(negedge clk);
    end
    drv_rx = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask
  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(exp_q.size()), 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1, "watchdog");
  end
  initial begin
    logic [10:0] pat;
    logic [7:0]  b;
    time         ta;
    int          n, d;
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    bus.rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 1);
    chk("rst_tx_ready", 32'(bus.tx_ready), 1);
    chk("rst_rx_valid", 32'(bus.rx_valid), 0);
    chk("rst_rx_data", 32'(bus.rx_data), 0);
    chk("rst_flags", 32'({bus.rx_parity_err, bus.rx_frame_err, bus.rx_overrun}), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    // 0xA5 with even parity: bit pattern on the line, ready-low length, loopback
    pat = {1'b1, 1'b0, 8'hA5, 1'b0};
    bus.tx_data  = 8'hA5;
    bus.tx_valid = 1'b1;
    exp_q.push_back('{8'hA5, 1'b0, 1'b0});
    @(posedge clk);
    ta = $time;
    #1;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h5A;
    chk("tx_start_edge", 32'(tx), 0);
    #321;
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("tx_bit%0d", i), 32'(tx), 32'(pat[i]));
      if (i == 3) begin
        bus.tx_valid = 1'b1;
        #20;
        bus.tx_valid = 1'b0;
        #620;
      end else if (i < 10) #640;
    end
    n = 0;
    while (!bus.tx_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    d = int'(($time - ta) / 10);
    checks++;
    if (d < 700 || d > 703) begin
      errs++;
      $display("FAIL tx_ready_low: low for %0d cycles, required 700..703", d);
    end
    wait_drain();
    for (int i = 0; i < 8; i++) begin
      b = i == 0 ? 8'h00 : i == 1 ? 8'hFF : i == 2 ? 8'h5A : 8'($urandom);
      send_tx(b, 1'b1);
    end
    wait_drain();
    loop = 1'b0;
    repeat (100) @(negedge clk);
    exp_q.push_back('{8'h3C, 1'b1, 1'b0});
    drive_rx(8'h3C, 1'b1, 1'b1);
    wait_drain();
    exp_q.push_back('{8'h96, 1'b0, 1'b1});
    drive_rx(8'h96, 1'b0, 1'b0);
    wait_drain();
    @(negedge clk);
    drv_rx = 1'b0;
    repeat (24) @(negedge clk);
    drv_rx = 1'b1;
    repeat (800) @(negedge clk);
    chk("glitch_no_valid", 32'(bus.rx_valid), 0);
    // consumer stalled: second frame must be dropped with a single overrun pulse
    bus.rx_ready = 1'b0;
    ovr_cnt = 0;
    exp_q.push_back('{8'h11, 1'b0, 1'b0});
    drive_rx(8'h11, 1'b0, 1'b1);
    drive_rx(8'h22, 1'b0, 1'b1);
    chk("ovr_held_valid", 32'(bus.rx_valid), 1);
    chk("ovr_held_data", 32'(bus.rx_data), 32'h11);
    chk("ovr_pulse_cycles", 32'(ovr_cnt), 1);
    bus.rx_ready = 1'b1;
    wait_drain();
    loop = 1'b1;
    send_tx(8'hC3, 1'b0);
    repeat (200) @(negedge clk);
    chk("tx_mid_frame", 32'(tx), 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_async_tx", 32'(tx), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    chk("post_rst_tx", 32'(tx), 1);
    chk("post_rst_tx_ready", 32'(bus.tx_ready), 1);
    chk("post_rst_rx_valid", 32'(bus.rx_valid), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
